// File: rtl/rv_iopmp_pkg.sv
// Shared types and constants for the IOPMP error responder.
package rv_iopmp_pkg;

   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_DRAIN = 2'd1,
      W_RESP  = 2'd2
   } err_wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_SEND = 1'b1
   } err_rd_state_e;

endpackage

// File: rtl/rv_iopmp_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module rv_iopmp_sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic                 inc_i,
   output logic [CNT_WIDTH-1:0] cnt_o
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise increment unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/rv_iopmp_err_responder.sv
// AXI sink for denied transactions: swallows AW/W and answers with an error
// B, or answers AR with a full-length burst of error R beats. Read and write
// sides are independent, each holding at most one transaction.
module rv_iopmp_err_responder
   import rv_iopmp_pkg::*;
#(
   parameter int         DATA_WIDTH = 64,
   parameter int         ID_WIDTH   = 8,
   parameter int         USER_WIDTH = 2,
   parameter logic [1:0] ERR_RESP   = RESP_SLVERR,
   parameter int         CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // write address
   input  logic                  aw_valid_i,
   output logic                  aw_ready_o,
   input  logic [ID_WIDTH-1:0]   aw_id_i,
   // write data
   input  logic                  w_valid_i,
   output logic                  w_ready_o,
   input  logic                  w_last_i,
   // write response
   output logic                  b_valid_o,
   input  logic                  b_ready_i,
   output logic [ID_WIDTH-1:0]   b_id_o,
   output logic [1:0]            b_resp_o,
   output logic [USER_WIDTH-1:0] b_user_o,
   // read address
   input  logic                  ar_valid_i,
   output logic                  ar_ready_o,
   input  logic [ID_WIDTH-1:0]   ar_id_i,
   input  logic [7:0]            ar_len_i,
   // read data
   output logic                  r_valid_o,
   input  logic                  r_ready_i,
   output logic [ID_WIDTH-1:0]   r_id_o,
   output logic [DATA_WIDTH-1:0] r_data_o,
   output logic [1:0]            r_resp_o,
   output logic                  r_last_o,
   output logic [USER_WIDTH-1:0] r_user_o,
   // status
   output logic                  busy_o,
   output logic [CNT_WIDTH-1:0]  wr_deny_cnt_o,
   output logic [CNT_WIDTH-1:0]  rd_deny_cnt_o
);

   err_wr_state_e       wr_state_q, wr_state_d;
   logic [ID_WIDTH-1:0] aw_id_q, aw_id_d;
   logic                wr_done;

   err_rd_state_e       rd_state_q, rd_state_d;
   logic [ID_WIDTH-1:0] ar_id_q, ar_id_d;
   logic [7:0]          ar_len_q, ar_len_d;
   logic [7:0]          beat_cnt_q, beat_cnt_d;
   logic                rd_last;
   logic                rd_done;

   // Write side next state: accept AW, drain W until last, then hold B.
   always_comb begin
      wr_state_d = wr_state_q;
      aw_id_d    = aw_id_q;
      wr_done    = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (aw_valid_i) begin
               aw_id_d    = aw_id_i;
               wr_state_d = W_DRAIN;
            end
         end
         W_DRAIN: begin
            if (w_valid_i && w_last_i) begin
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (b_ready_i) begin
               wr_done    = 1'b1;
               wr_state_d = W_IDLE;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   // Write side registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_state_q <= W_IDLE;
         aw_id_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         aw_id_q    <= aw_id_d;
      end
   end

   // Handshake outputs come from state alone, so no input reaches an output.
   assign aw_ready_o = (wr_state_q == W_IDLE);
   assign w_ready_o  = (wr_state_q == W_DRAIN);
   assign b_valid_o  = (wr_state_q == W_RESP);
   assign b_id_o     = aw_id_q;
   assign b_resp_o   = ERR_RESP;
   assign b_user_o   = '0;

   assign rd_last = (beat_cnt_q == ar_len_q);

   // Read side next state: latch AR, then emit len+1 beats with RLAST on the final one.
   always_comb begin
      rd_state_d = rd_state_q;
      ar_id_d    = ar_id_q;
      ar_len_d   = ar_len_q;
      beat_cnt_d = beat_cnt_q;
      rd_done    = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            if (ar_valid_i) begin
               ar_id_d    = ar_id_i;
               ar_len_d   = ar_len_i;
               beat_cnt_d = '0;
               rd_state_d = R_SEND;
            end
         end
         R_SEND: begin
            if (r_ready_i) begin
               if (rd_last) begin
                  // Hold the count on the final beat so len=255 never wraps to 0.
                  rd_done    = 1'b1;
                  rd_state_d = R_IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + 8'd1;
               end
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   // Read side registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_state_q <= R_IDLE;
         ar_id_q    <= '0;
         ar_len_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         ar_id_q    <= ar_id_d;
         ar_len_q   <= ar_len_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign ar_ready_o = (rd_state_q == R_IDLE);
   assign r_valid_o  = (rd_state_q == R_SEND);
   assign r_last_o   = (rd_state_q == R_SEND) && rd_last;
   assign r_id_o     = ar_id_q;
   assign r_data_o   = '0;
   assign r_resp_o   = ERR_RESP;
   assign r_user_o   = '0;

   assign busy_o = (wr_state_q != W_IDLE) || (rd_state_q != R_IDLE);

   rv_iopmp_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .inc_i (wr_done),
      .cnt_o (wr_deny_cnt_o)
   );

   rv_iopmp_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .inc_i (rd_done),
      .cnt_o (rd_deny_cnt_o)
   );

endmodule

// File: tb/tb_rv_iopmp_err_responder.sv
// Directed bench for the error responder; R and B beats are checked against
// queues of expected beats filled when each request is driven.
module tb_rv_iopmp_err_responder;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          aw_valid_i, aw_ready_o;
   logic [7:0]    aw_id_i;
   logic          w_valid_i, w_ready_o, w_last_i;
   logic          b_valid_o, b_ready_i;
   logic [7:0]    b_id_o;
   logic [1:0]    b_resp_o, b_user_o;
   logic          ar_valid_i, ar_ready_o;
   logic [7:0]    ar_id_i, ar_len_i;
   logic          r_valid_o, r_ready_i;
   logic [7:0]    r_id_o;
   logic [63:0]   r_data_o;
   logic [1:0]    r_resp_o, r_user_o;
   logic          r_last_o;
   logic          busy_o;
   logic [CW-1:0] wr_deny_cnt_o, rd_deny_cnt_o;

   rv_iopmp_err_responder #(
      .DATA_WIDTH(64), .ID_WIDTH(8), .USER_WIDTH(2), .ERR_RESP(2'b10), .CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
      .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
      .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o),
      .b_resp_o(b_resp_o), .b_user_o(b_user_o),
      .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_len_i(ar_len_i),
      .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
      .r_resp_o(r_resp_o), .r_last_o(r_last_o), .r_user_o(r_user_o),
      .busy_o(busy_o), .wr_deny_cnt_o(wr_deny_cnt_o), .rd_deny_cnt_o(rd_deny_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] id;
      logic       last;
   } rexp_t;

   rexp_t      rq[$];
   logic [7:0] bq[$];
   int         checks = 0;
   int         errors = 0;
   int         exp_wr = 0;
   int         exp_rd = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Beat monitor: every visible R/B beat must match the head of its queue;
   // the head is only popped on handshake, so stalled beats must stay stable.
   always @(negedge clk) begin
      if (!rst_i) begin
         if (r_valid_o) begin
            if (rq.size() == 0) begin
               chk("r_spurious_valid", {63'b0, r_valid_o}, 64'd0);
            end else begin
               chk("r_id", {56'b0, r_id_o}, {56'b0, rq[0].id});
               chk("r_last", {63'b0, r_last_o}, {63'b0, rq[0].last});
               chk("r_data", r_data_o, 64'd0);
               chk("r_resp", {62'b0, r_resp_o}, 64'd2);
               chk("r_user", {62'b0, r_user_o}, 64'd0);
               if (r_ready_i) void'(rq.pop_front());
            end
         end
         if (b_valid_o) begin
            if (bq.size() == 0) begin
               chk("b_spurious_valid", {63'b0, b_valid_o}, 64'd0);
            end else begin
               chk("b_id", {56'b0, b_id_o}, {56'b0, bq[0]});
               chk("b_resp", {62'b0, b_resp_o}, 64'd2);
               chk("b_user", {62'b0, b_user_o}, 64'd0);
               if (b_ready_i) void'(bq.pop_front());
            end
         end
      end
   end

   function automatic int sat(input int v);
      return (v >= 15) ? 15 : v + 1;
   endfunction

   task automatic wait_aw();
      int n = 0;
      logic rdy;
      do begin
         @(negedge clk); rdy = aw_ready_o;
         @(posedge clk); #1; n++;
      end while (!rdy && n < 50);
      chk("aw_handshake", {63'b0, rdy}, 64'd1);
   endtask

   task automatic wait_ar();
      int n = 0;
      logic rdy;
      do begin
         @(negedge clk); rdy = ar_ready_o;
         @(posedge clk); #1; n++;
      end while (!rdy && n < 50);
      chk("ar_handshake", {63'b0, rdy}, 64'd1);
   endtask

   task automatic wait_w(output int n);
      logic rdy;
      n = 0;
      do begin
         @(negedge clk); rdy = w_ready_o;
         @(posedge clk); #1; n++;
      end while (!rdy && n < 50);
      chk("w_handshake", {63'b0, rdy}, 64'd1);
   endtask

   task automatic do_write(input logic [7:0] id, input int nb);
      int n;
      aw_valid_i = 1'b1; aw_id_i = id;
      bq.push_back(id);
      wait_aw();
      aw_valid_i = 1'b0;
      for (int i = 0; i < nb; i++) begin
         w_valid_i = 1'b1; w_last_i = (i == nb - 1);
         wait_w(n);
         if (i == 0) chk("w_first_latency", 64'(n), 64'd1);
      end
      w_valid_i = 1'b0; w_last_i = 1'b0;
      @(negedge clk);
      chk("b_valid_latency", {63'b0, b_valid_o}, 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      exp_wr = sat(exp_wr);
      chk("wr_deny_cnt", 64'(wr_deny_cnt_o), 64'(exp_wr));
      chk("aw_ready_after_b", {63'b0, aw_ready_o}, 64'd1);
      chk("b_queue_drained", 64'(bq.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [7:0] id, input logic [7:0] len, input bit toggle);
      int n = 0;
      rexp_t e;
      for (int i = 0; i <= int'(len); i++) begin
         e.id = id; e.last = (i == int'(len));
         rq.push_back(e);
      end
      ar_valid_i = 1'b1; ar_id_i = id; ar_len_i = len; r_ready_i = 1'b1;
      wait_ar();
      ar_valid_i = 1'b0;
      @(negedge clk);
      chk("r_first_latency", {63'b0, r_valid_o}, 64'd1);
      chk("busy_during_read", {63'b0, busy_o}, 64'd1);
      while (rq.size() != 0 && n < 2 * (int'(len) + 1) + 20) begin
         @(posedge clk); #1; n++;
         if (toggle) r_ready_i = ~r_ready_i;
      end
      chk("r_burst_complete", 64'(rq.size()), 64'd0);
      r_ready_i = 1'b1;
      @(negedge clk);
      exp_rd = sat(exp_rd);
      chk("rd_deny_cnt", 64'(rd_deny_cnt_o), 64'(exp_rd));
      chk("r_idle_after_burst", {63'b0, r_valid_o}, 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      rexp_t e;
      rst_i = 1'b1;
      aw_valid_i = 0; aw_id_i = 0; w_valid_i = 0; w_last_i = 0; b_ready_i = 1;
      ar_valid_i = 0; ar_id_i = 0; ar_len_i = 0; r_ready_i = 1;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_aw_ready", {63'b0, aw_ready_o}, 64'd1);
      chk("rst_ar_ready", {63'b0, ar_ready_o}, 64'd1);
      chk("rst_w_ready", {63'b0, w_ready_o}, 64'd0);
      chk("rst_b_valid", {63'b0, b_valid_o}, 64'd0);
      chk("rst_r_valid", {63'b0, r_valid_o}, 64'd0);
      chk("rst_r_last", {63'b0, r_last_o}, 64'd0);
      chk("rst_busy", {63'b0, busy_o}, 64'd0);
      chk("rst_wr_cnt", 64'(wr_deny_cnt_o), 64'd0);
      chk("rst_rd_cnt", 64'(rd_deny_cnt_o), 64'd0);
      @(posedge clk); #1;

      // 4-beat write, then reads: backpressured, single beat, maximum length
      do_write(8'h3C, 4);
      do_read(8'h51, 8'd3, 1'b1);
      do_read(8'h22, 8'd0, 1'b0);
      do_read(8'h7E, 8'd255, 1'b0);

      // AW and AR in the same cycle
      aw_valid_i = 1'b1; aw_id_i = 8'hA5;
      ar_valid_i = 1'b1; ar_id_i = 8'h5A; ar_len_i = 8'd1;
      bq.push_back(8'hA5);
      e.id = 8'h5A; e.last = 1'b0; rq.push_back(e);
      e.last = 1'b1; rq.push_back(e);
      @(negedge clk);
      chk("conc_aw_ready", {63'b0, aw_ready_o}, 64'd1);
      chk("conc_ar_ready", {63'b0, ar_ready_o}, 64'd1);
      @(posedge clk); #1;
      aw_valid_i = 1'b0; ar_valid_i = 1'b0;
      w_valid_i = 1'b1; w_last_i = 1'b1;
      wait_w(n);
      w_valid_i = 1'b0; w_last_i = 1'b0;
      n = 0;
      while ((rq.size() != 0 || bq.size() != 0) && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("conc_drained", 64'(rq.size() + bq.size()), 64'd0);
      @(negedge clk);
      exp_wr = sat(exp_wr); exp_rd = sat(exp_rd);
      chk("conc_wr_cnt", 64'(wr_deny_cnt_o), 64'(exp_wr));
      chk("conc_rd_cnt", 64'(rd_deny_cnt_o), 64'(exp_rd));
      @(posedge clk); #1;

      // saturation: 15 more writes brings the total to 17
      for (int i = 0; i < 15; i++) do_write(8'(i + 1), (i % 3) + 1);
      chk("wr_cnt_saturated", 64'(wr_deny_cnt_o), 64'd15);

      // reset in the middle of an 8-beat read
      n = 0;
      for (int i = 0; i < 8; i++) begin
         e.id = 8'h66; e.last = (i == 7); rq.push_back(e);
      end
      ar_valid_i = 1'b1; ar_id_i = 8'h66; ar_len_i = 8'd7; r_ready_i = 1'b1;
      wait_ar();
      ar_valid_i = 1'b0;
      while (rq.size() > 5 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("mid_beats_before_reset", 64'(rq.size()), 64'd5);
      r_ready_i = 1'b0; rst_i = 1'b1;
      @(posedge clk); #1;
      rq.delete();
      @(negedge clk);
      chk("mid_r_valid_after_rst", {63'b0, r_valid_o}, 64'd0);
      chk("mid_ar_ready_after_rst", {63'b0, ar_ready_o}, 64'd1);
      @(posedge clk); #1;
      rst_i = 1'b0; r_ready_i = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_no_residual_busy", {63'b0, busy_o}, 64'd0);
      chk("mid_rd_cnt_cleared", 64'(rd_deny_cnt_o), 64'd0);
      chk("mid_wr_cnt_cleared", 64'(wr_deny_cnt_o), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_iopmp_err_responder.md
Name: rv_iopmp_err_responder

Overview:
- Terminating stage downstream of the IOPMP data abstractor's deny path.
- Every AXI transaction the transaction logic rejects is steered here instead of to the initiator port.
- Acts as an AXI slave sink:
  - accepts the denied AW/AR;
  - drains the write data beats;
  - returns a single error B response, or a burst of error R beats with correct length and RLAST.
- Read and write channels are independent; one outstanding transaction per direction.

Parameters:
- DATA_WIDTH, 64, R data width in bits.
- ID_WIDTH, 8, AXI ID width.
- USER_WIDTH, 2, R/B user width; user outputs are driven to 0.
- ERR_RESP, 2'b10, response code on B/R (SLVERR; 2'b11 selects DECERR).
- CNT_WIDTH, 16, width of the saturating deny counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- aw_valid_i  in  1  denied write address valid.
- aw_ready_o  out  1  write address accepted.
- aw_id_i  in  ID_WIDTH  write transaction ID.
- w_valid_i  in  1  write data beat valid.
- w_ready_o  out  1  write data beat accepted (discarded).
- w_last_i  in  1  last write beat.
- b_valid_o  out  1  write response valid.
- b_ready_i  in  1  write response accepted.
- b_id_o  out  ID_WIDTH  echoed AW ID.
- b_resp_o  out  2  ERR_RESP.
- b_user_o  out  USER_WIDTH  constant 0.
- ar_valid_i  in  1  denied read address valid.
- ar_ready_o  out  1  read address accepted.
- ar_id_i  in  ID_WIDTH  read transaction ID.
- ar_len_i  in  8  burst length minus one.
- r_valid_o  out  1  read beat valid.
- r_ready_i  in  1  read beat accepted.
- r_id_o  out  ID_WIDTH  echoed AR ID.
- r_data_o  out  DATA_WIDTH  constant 0.
- r_resp_o  out  2  ERR_RESP.
- r_last_o  out  1  final read beat.
- r_user_o  out  USER_WIDTH  constant 0.
- busy_o  out  1  either FSM not idle.
- wr_deny_cnt_o  out  CNT_WIDTH  saturating count of completed write error responses.
- rd_deny_cnt_o  out  CNT_WIDTH  saturating count of completed read error bursts.

Behaviour:
- Reset (rst_i high at a rising edge):
  - both FSMs go to IDLE; ID registers and beat counter clear to 0; deny counters clear to 0.
  - outputs in reset state: aw_ready_o=1, ar_ready_o=1, w_ready_o=0, b_valid_o=0, r_valid_o=0, r_last_o=0, busy_o=0.
- Reset mid-burst: abandons the transaction with no further beats or responses. Upstream is reset in the same domain.
- Write FSM, states W_IDLE, W_DRAIN, W_RESP. All ready/valid outputs are decoded from registered state only; no combinational input-to-output path.
  - W_IDLE: aw_ready_o=1. On aw_valid_i, latch aw_id_i and go to W_DRAIN.
  - W_DRAIN: w_ready_o=1, each beat discarded. A handshake with w_last_i=1 goes to W_RESP.
  - W_RESP: b_valid_o=1, b_id_o=latched ID. Hold stable until b_ready_i. On handshake, increment wr_deny_cnt_o and go to W_IDLE.
  - W beats presented while in W_IDLE or W_RESP are not accepted (w_ready_o=0). Upstream orders W after AW.
  - Minimum latency: AW handshake at cycle N, first W accepted at N+1. A single-beat write gives B valid at N+2, next AW accepted at N+3.
- Read FSM, states R_IDLE, R_SEND:
  - R_IDLE: ar_ready_o=1. On ar_valid_i, latch ar_id_i and ar_len_i, clear beat_cnt (8 bits), go to R_SEND.
  - R_SEND: r_valid_o=1; r_last_o=(beat_cnt==latched len).
  - Each r_ready_i handshake increments beat_cnt.
  - Handshake with r_last_o: increment rd_deny_cnt_o, go to R_IDLE.
  - Outputs stay stable while r_valid_o=1 and r_ready_i=0.
  - len=0 gives a single beat with r_last_o=1. len=255 gives 256 beats; beat_cnt reaches 255 and never wraps inside the burst.
  - Latency: AR handshake at N, first R valid at N+1; burst of L+1 beats at full throughput.
- Channels run concurrently; simultaneous AW and AR handshakes in the same cycle are both accepted.
- Deny counters saturate at all-ones and do not wrap.
- busy_o = (write FSM != W_IDLE) | (read FSM != R_IDLE).

Decomposition:
- Into rv_iopmp_pkg:
  - state enums err_wr_state_e and err_rd_state_e;
  - localparams RESP_SLVERR=2'b10 and RESP_DECERR=2'b11.
- One natural sub-module: rv_iopmp_sat_counter (CNT_WIDTH parameter; inputs inc_i, clr_i; output cnt_o), instantiated twice.
- Both FSMs stay in the top module.

Test Plan:
- Reset check: assert rst_i 2 cycles, then release -> aw_ready_o=1, ar_ready_o=1, b_valid_o=0, r_valid_o=0, both counters 0.
- Write, 4 beats: AW id=0x3C, then 4 W beats, last with w_last_i=1, b_ready_i=1 -> b_valid_o the cycle after last beat, b_id_o=0x3C, b_resp_o=2'b10, wr_deny_cnt_o=1.
- Read with backpressure: AR id=0x51 len=3, r_ready_i toggling 1,0,1,0… -> exactly 4 R beats, r_id_o=0x51, r_data_o=0, r_last_o only on the 4th, outputs stable while stalled, rd_deny_cnt_o=1.
- Boundary lengths: AR len=0 -> one beat with r_last_o=1. AR len=255 -> 256 beats, last flagged only on beat 256.
- Concurrency and saturation: AW and AR in the same cycle -> both accepted, B and R completed independently. With CNT_WIDTH=4, 17 writes -> wr_deny_cnt_o holds 15.
- Reset mid-burst: AR len=7, assert rst_i after 3 beats -> r_valid_o=0 next cycle, FSM in R_IDLE, no residual beats after release.
